// File: rtl/display_update_ctrl.sv
// Update sequencer for the serialized display output stage.
// Collects rewrite requests (time change, blink phase change, config request,
// periodic refresh) into two pending flags and runs one transfer at a time,
// config first. Time and decimal points are snapshotted at transfer start so
// the display stage sees stable data until it acknowledges.
//
// Handshake with the display stage: o_stb is held high while in a REQ state
// and may overlap the first busy cycle; the transfer is accepted on the first
// clock where i_busy is sampled high. It is complete on the single-cycle
// i_ack pulse seen in WAIT. Any i_ack outside WAIT is ignored. If no ack
// arrives within TIMEOUT_CYCLES in WAIT, the transfer is aborted and re-queued.
module display_update_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_time_change,
  input  logic [4:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  input  logic       i_colon_en,
  input  logic       i_blink,
  input  logic       i_config_req,
  input  logic       i_busy,
  input  logic       i_ack,
  output logic       o_stb,
  output logic       o_write_config,
  output logic [4:0] o_hours,
  output logic [5:0] o_minutes,
  output logic [5:0] o_seconds,
  output logic [5:0] o_dp,
  output logic       o_timeout,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CFG_REQ  = 2'd1,
    S_DISP_REQ = 2'd2,
    S_WAIT     = 2'd3
  } state_t;

  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);
  localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);
  // Colon dots sit on the hours LSD (bit 1) and minutes LSD (bit 3).
  localparam logic [5:0]  COLON_DP     = 6'b001010;

  state_t      state;
  state_t      state_next;
  logic        cfg_pending;
  logic        disp_pending;
  logic        blink_q;
  logic [31:0] refresh_cnt;
  logic [15:0] tmo_cnt;
  logic        cfg_xfer_q;

  logic        start_cfg;
  logic        start_disp;
  logic        abort;
  logic        refresh_hit;
  logic        blink_evt;
  logic        cfg_set;
  logic        disp_set;

  assign refresh_hit = (refresh_cnt == REFRESH_LAST);
  assign blink_evt   = (i_blink != blink_q);
  // An aborted transfer re-queues its own type so it is retried.
  assign cfg_set     = i_config_req | refresh_hit | (abort & cfg_xfer_q);
  assign disp_set    = i_time_change | blink_evt | refresh_hit | (abort & ~cfg_xfer_q);

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic and transfer start/abort strobes.
  always_comb begin
    state_next = state;
    start_cfg  = 1'b0;
    start_disp = 1'b0;
    abort      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_pending) begin
          state_next = S_CFG_REQ;
          start_cfg  = 1'b1;
        end else if (disp_pending) begin
          state_next = S_DISP_REQ;
          start_disp = 1'b1;
        end
      end
      S_CFG_REQ, S_DISP_REQ: begin
        if (i_busy) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_ack) begin
          state_next = S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = S_IDLE;
          abort      = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state; config flag holds through WAIT.
  always_comb begin
    o_stb          = 1'b0;
    o_write_config = 1'b0;
    case (state)
      S_CFG_REQ: begin
        o_stb          = 1'b1;
        o_write_config = 1'b1;
      end
      S_DISP_REQ: o_stb = 1'b1;
      S_WAIT:     o_write_config = cfg_xfer_q;
      default: ;
    endcase
  end

  assign o_state = state;

  // Pending flags: a set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cfg_pending  <= 1'b1;
      disp_pending <= 1'b1;
    end else begin
      if (cfg_set)        cfg_pending <= 1'b1;
      else if (start_cfg) cfg_pending <= 1'b0;
      if (disp_set)        disp_pending <= 1'b1;
      else if (start_disp) disp_pending <= 1'b0;
    end
  end

  // Blink edge register and free-running refresh counter.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blink_q     <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      blink_q     <= i_blink;
      refresh_cnt <= refresh_hit ? '0 : refresh_cnt + 32'd1;
    end
  end

  // Transfer timeout counter: cleared on every state change, saturating.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                   tmo_cnt <= '0;
    else if (state_next != state)  tmo_cnt <= '0;
    else if (state != S_IDLE && tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 16'd1;
  end

  // Snapshot of display data and transfer type, taken only on IDLE->REQ.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_hours    <= '0;
      o_minutes  <= '0;
      o_seconds  <= '0;
      o_dp       <= '0;
      cfg_xfer_q <= 1'b0;
    end else if (start_cfg | start_disp) begin
      o_hours    <= i_hours;
      o_minutes  <= i_minutes;
      o_seconds  <= i_seconds;
      o_dp       <= (i_colon_en & i_blink) ? COLON_DP : 6'b000000;
      cfg_xfer_q <= start_cfg;
    end
  end

  // Sticky timeout indication, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)    o_timeout <= 1'b0;
    else if (abort) o_timeout <= 1'b1;
  end

endmodule

// File: tb/tb_display_update_ctrl.sv
// Directed bench for display_update_ctrl with a behavioural display stage
// and a queue of expected transfers {write_config, hours, minutes, seconds, dp}.
module tb_display_update_ctrl;

  localparam int REFRESH  = 1000;
  localparam int TMO      = 64;
  localparam int BUSY_LEN = 20;
  localparam logic [5:0] COLON = 6'b001010;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_time_change = 1'b0;
  logic [4:0] i_hours = '0;
  logic [5:0] i_minutes = '0;
  logic [5:0] i_seconds = '0;
  logic       i_colon_en = 1'b0;
  logic       i_blink = 1'b0;
  logic       i_config_req = 1'b0;
  logic       i_busy = 1'b0;
  logic       i_ack = 1'b0;
  logic       o_stb;
  logic       o_write_config;
  logic [4:0] o_hours;
  logic [5:0] o_minutes;
  logic [5:0] o_seconds;
  logic [5:0] o_dp;
  logic       o_timeout;
  logic [1:0] o_state;

  always #5 i_clk = ~i_clk;

  display_update_ctrl #(.REFRESH_CYCLES(REFRESH), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_time_change(i_time_change),
    .i_hours(i_hours), .i_minutes(i_minutes), .i_seconds(i_seconds),
    .i_colon_en(i_colon_en), .i_blink(i_blink), .i_config_req(i_config_req),
    .i_busy(i_busy), .i_ack(i_ack), .o_stb(o_stb), .o_write_config(o_write_config),
    .o_hours(o_hours), .o_minutes(o_minutes), .o_seconds(o_seconds), .o_dp(o_dp),
    .o_timeout(o_timeout), .o_state(o_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_assert = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  logic [23:0] exp_item;
  logic [22:0] snap;
  logic        snap_valid = 1'b0;
  logic        stb_prev = 1'b0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  int          last_ack_cyc = 0;
  int          last_stb_cyc = 0;
  int          last_gap = 0;
  int          m_phase = 0;
  int          m_cnt = 0;
  bit          no_ack = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk(logic wc, logic [4:0] h, logic [5:0] m,
                                     logic [5:0] s, logic [5:0] dp);
    return {wc, h, m, s, dp};
  endfunction

  function automatic logic [5:0] cur_dp();
    return (i_colon_en & i_blink) ? COLON : 6'b000000;
  endfunction

  // Display-stage model plus output monitor, both on the falling edge.
  always @(negedge i_clk) begin
    cyc++;
    if (i_reset) begin
      i_busy     = 1'b0;
      i_ack      = 1'b0;
      m_phase    = 0;
      stb_prev   = 1'b0;
      snap_valid = 1'b0;
    end else begin
      if (o_stb && !stb_prev) begin
        xfer_cnt++;
        last_gap     = cyc - last_ack_cyc;
        last_stb_cyc = cyc;
        exp_item     = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
        chk("xfer", 32'({o_write_config, o_hours, o_minutes, o_seconds, o_dp}), 32'(exp_item));
        snap       = {o_hours, o_minutes, o_seconds, o_dp};
        snap_valid = 1'b1;
      end else if (snap_valid) begin
        chk("snap_stable", 32'({o_hours, o_minutes, o_seconds, o_dp}), 32'(snap));
      end
      stb_prev = o_stb;
      case (m_phase)
        0: begin
          i_ack = 1'b0;
          if (o_stb) begin
            i_busy  = 1'b1;
            m_cnt   = BUSY_LEN;
            m_phase = 1;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            i_busy = 1'b0;
            if (!no_ack) begin
              i_ack        = 1'b1;
              last_ack_cyc = cyc;
              done_cnt++;
              m_phase      = 2;
            end else begin
              m_phase = 0;
            end
          end
        end
        default: begin
          i_ack   = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(negedge i_clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_time(logic [4:0] h, logic [5:0] m, logic [5:0] s);
    i_hours = h; i_minutes = m; i_seconds = s;
    i_time_change = 1'b1;
    cycle();
    i_time_change = 1'b0;
  endtask

  task automatic wait_done(int target, int budget, string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin cycle(); k++; end
    chk(tag, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_xfer(int target, int budget, string tag);
    int k = 0;
    while (xfer_cnt < target && k < budget) begin cycle(); k++; end
    chk(tag, 32'(xfer_cnt), 32'(target));
  endtask

  // Assert reset; every output must drop in the same cycle.
  task automatic start_reset();
    i_reset = 1'b1;
    #1;
    chk("reset_outputs", 32'({o_stb, o_write_config, o_hours, o_minutes, o_seconds,
                              o_dp, o_timeout, o_state}), 32'd0);
    exp_q.delete();
  endtask

  // Release reset: config write within 2 cycles, digit write 2 cycles after its ack, then quiet.
  task automatic finish_reset();
    int bx, bd, k;
    cycle(); cycle();
    chk("reset_held", 32'({o_stb, o_hours, o_minutes, o_seconds, o_dp, o_timeout, o_state}), 32'd0);
    exp_q.push_back(mk(1'b1, i_hours, i_minutes, i_seconds, cur_dp()));
    exp_q.push_back(mk(1'b0, i_hours, i_minutes, i_seconds, cur_dp()));
    bx = xfer_cnt;
    bd = done_cnt;
    i_reset = 1'b0;
    k = 0;
    while (xfer_cnt == bx && k < 2) begin cycle(); k++; end
    chk("cfg_stb_latency", 32'(xfer_cnt), 32'(bx + 1));
    chk("cfg_first_wc", 32'(o_write_config), 32'd1);
    wait_done(bd + 2, 120, "reset_pair_done");
    chk("digit_after_cfg_gap", 32'(last_gap), 32'd2);
    idle(30);
    chk("reset_no_extra_stb", 32'(xfer_cnt), 32'(bx + 2));
  endtask

  // ---------------- directed sequence ----------------
  int bx, bd, stb_cyc;

  initial begin
    // Reset release with all inputs zero.
    i_reset = 1'b1;
    cycle(); cycle();
    start_reset();
    finish_reset();

    // Time update, held snapshot, single follow-up transfer.
    start_reset();
    i_colon_en = 1'b1; i_blink = 1'b1;
    finish_reset();
    bx = xfer_cnt; bd = done_cnt;
    exp_q.push_back(mk(1'b0, 5'd13, 6'd45, 6'd7, COLON));
    pulse_time(5'd13, 6'd45, 6'd7);
    wait_xfer(bx + 1, 5, "time_stb");
    chk("time_hours", 32'(o_hours), 32'd13);
    chk("time_minutes", 32'(o_minutes), 32'd45);
    chk("time_seconds", 32'(o_seconds), 32'd7);
    chk("time_dp", 32'(o_dp), 32'(COLON));
    idle(3);
    exp_q.push_back(mk(1'b0, 5'd13, 6'd45, 6'd8, COLON));
    pulse_time(5'd13, 6'd45, 6'd8);
    idle(2);
    chk("time_hold_seconds", 32'(o_seconds), 32'd7);
    wait_done(bd + 2, 120, "time_pair_done");
    idle(30);
    chk("time_one_followup", 32'(xfer_cnt), 32'(bx + 2));

    // Blink toggle only, then colon disabled.
    bx = xfer_cnt; bd = done_cnt;
    exp_q.push_back(mk(1'b0, 5'd13, 6'd45, 6'd8, 6'd0));
    i_blink = 1'b0;
    wait_done(bd + 1, 60, "blink_done");
    chk("blink_dp_off", 32'(o_dp), 32'd0);
    i_colon_en = 1'b0;
    exp_q.push_back(mk(1'b0, 5'd13, 6'd45, 6'd8, 6'd0));
    i_blink = 1'b1;
    wait_done(bd + 2, 60, "colon_off_done");
    chk("colon_off_dp", 32'(o_dp), 32'd0);
    idle(30);
    chk("blink_no_extra", 32'(xfer_cnt), 32'(bx + 2));

    // Coalescing of several events raised during WAIT.
    start_reset();
    finish_reset();
    bx = xfer_cnt; bd = done_cnt;
    exp_q.push_back(mk(1'b0, 5'd1, 6'd2, 6'd3, 6'd0));
    pulse_time(5'd1, 6'd2, 6'd3);
    wait_xfer(bx + 1, 5, "coal_first_stb");
    idle(2);
    exp_q.push_back(mk(1'b1, 5'd1, 6'd2, 6'd6, 6'd0));
    exp_q.push_back(mk(1'b0, 5'd1, 6'd2, 6'd6, 6'd0));
    pulse_time(5'd1, 6'd2, 6'd4);
    pulse_time(5'd1, 6'd2, 6'd5);
    i_config_req = 1'b1;
    pulse_time(5'd1, 6'd2, 6'd6);
    i_config_req = 1'b0;
    wait_done(bd + 3, 150, "coal_done");
    idle(30);
    chk("coal_count", 32'(xfer_cnt), 32'(bx + 3));

    // Timeout: stalled transfer aborts after TMO cycles in WAIT and is retried.
    start_reset();
    finish_reset();
    bx = xfer_cnt; bd = done_cnt;
    no_ack = 1'b1;
    exp_q.push_back(mk(1'b0, 5'd2, 6'd3, 6'd4, 6'd0));
    exp_q.push_back(mk(1'b0, 5'd2, 6'd3, 6'd4, 6'd0));
    pulse_time(5'd2, 6'd3, 6'd4);
    wait_xfer(bx + 1, 5, "tmo_first_stb");
    stb_cyc = last_stb_cyc;
    chk("tmo_clear_before", 32'(o_timeout), 32'd0);
    for (int k = 0; k < 120 && !o_timeout; k++) cycle();
    chk("tmo_cycles", 32'(cyc - stb_cyc), 32'(TMO + 1));
    chk("tmo_state_idle", 32'(o_state), 32'd0);
    chk("tmo_flag", 32'(o_timeout), 32'd1);
    no_ack = 1'b0;
    wait_xfer(bx + 2, 3, "tmo_retry_stb");
    chk("tmo_retry_type", 32'(o_write_config), 32'd0);
    wait_done(bd + 1, 60, "tmo_retry_done");
    idle(5);
    chk("tmo_sticky", 32'(o_timeout), 32'd1);
    chk("tmo_count", 32'(xfer_cnt), 32'(bx + 2));

    // Periodic refresh, then reset in the middle of WAIT.
    start_reset();
    finish_reset();
    bx = xfer_cnt; bd = done_cnt;
    exp_q.push_back(mk(1'b1, i_hours, i_minutes, i_seconds, cur_dp()));
    exp_q.push_back(mk(1'b0, i_hours, i_minutes, i_seconds, cur_dp()));
    idle(850);
    chk("refresh_not_early", 32'(xfer_cnt), 32'(bx));
    wait_done(bd + 2, 300, "refresh_done");
    chk("refresh_count", 32'(xfer_cnt), 32'(bx + 2));
    bx = xfer_cnt;
    exp_q.push_back(mk(1'b0, 5'd5, 6'd6, 6'd7, 6'd0));
    pulse_time(5'd5, 6'd6, 6'd7);
    wait_xfer(bx + 1, 5, "midreset_stb");
    idle(5);
    chk("midreset_in_wait", 32'(o_state), 32'd3);
    start_reset();
    finish_reset();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/display_update_ctrl.md
Name: display_update_ctrl

Overview:
- Upstream sequencer for the serialized display output stage. Decides when the display is rewritten and drives that stage's strobe/busy/ack handshake.
- Sources of a rewrite: clock time changes, colon blink phase changes, post-reset configuration, periodic refresh.
- Snapshots time and decimal-point data so the display stage sees stable inputs for a whole transfer.
- Recovers from a stalled transfer by timeout and retry.

Parameters:
- REFRESH_CYCLES, 10_000_000: clock cycles between forced config+digit rewrites (≥2, fits 32 bits).
- TIMEOUT_CYCLES, 4096: max cycles in WAIT before abort (≥2, fits 16 bits).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high
- i_time_change  in  1  one-cycle pulse: time registers updated
- i_hours  in  5  hours 0-23
- i_minutes  in  6  minutes 0-59
- i_seconds  in  6  seconds 0-59
- i_colon_en  in  1  enable colon decimal points
- i_blink  in  1  colon blink phase, level
- i_config_req  in  1  one-cycle pulse: request config rewrite
- i_busy  in  1  display stage busy
- i_ack  in  1  display stage done, one-cycle pulse
- o_stb  out  1  start display transfer
- o_write_config  out  1  transfer is a config write, valid with o_stb
- o_hours  out  5  snapshot hours
- o_minutes  out  6  snapshot minutes
- o_seconds  out  6  snapshot seconds
- o_dp  out  6  snapshot decimal points; bit 0 = hours MSD … bit 5 = seconds LSD
- o_timeout  out  1  sticky: a transfer timed out; cleared only by reset

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE; all outputs 0.
  - cfg_pending=1, disp_pending=1, so the first action after reset is a config write, then a digit write.
  - Refresh counter=0; blink edge register=0.
- Pending flags, set on any cycle, any state:
  - i_config_req sets cfg_pending.
  - i_time_change sets disp_pending.
  - A change of i_blink versus its registered value sets disp_pending.
  - Refresh counter reaching REFRESH_CYCLES-1 sets both flags and wraps to 0.
  - Set and clear in the same cycle: set wins. The new event is serviced by a later transfer.
- States:
  - IDLE:
    - cfg_pending=1 → CFG_REQ. Config takes priority.
    - Else disp_pending=1 → DISP_REQ.
    - On this transition, clear the flag being serviced.
    - On this transition, snapshot i_hours/i_minutes/i_seconds into o_hours/o_minutes/o_seconds.
    - On this transition, o_dp ← 6'b001010 if i_colon_en & i_blink, else 0.
  - CFG_REQ / DISP_REQ:
    - o_stb=1; o_write_config=1 only in CFG_REQ.
    - Leave for WAIT the cycle after i_busy is sampled 1.
    - o_stb may stay high for that one extra cycle. The display stage ignores stb while busy.
  - WAIT:
    - o_stb=0; o_write_config holds its value.
    - i_ack=1 → IDLE.
    - Timeout counter reaches TIMEOUT_CYCLES-1 → IDLE, set o_timeout, re-set the flag of the aborted transfer.
  - The timeout counter also runs in REQ states. It clears on every state change.
- Snapshot outputs change only on IDLE→REQ. They are constant from the first o_stb through i_ack.
- Latency: IDLE with a flag set → o_stb high on the next cycle. Back-to-back config then digits: the digit o_stb is asserted 2 cycles after the config i_ack.
- i_ack outside WAIT is ignored.
- A new i_time_change during a transfer does not alter the snapshot. It is serviced after.
- Reset mid-transfer: immediate return to IDLE, outputs 0, both flags set.
- o_dp MSB/LSB mapping is fixed: bit index = digit position, hours MSD = 0.

Test Plan (REFRESH_CYCLES=1000, TIMEOUT_CYCLES=64, display-stage model: busy 1 cycle after stb for 20 cycles, then ack):
- Reset release:
  - Required: o_stb with o_write_config=1 within 2 cycles, then ack.
  - Required: next o_stb has o_write_config=0.
  - Required: no further stb until an event.
- Time update:
  - Stimulus: i_time_change with 13:45:07, i_colon_en=1, i_blink=1.
  - Required: o_hours=13, o_minutes=45, o_seconds=7, o_dp=6'b001010.
  - Required: values held unchanged while inputs change to 13:45:08 mid-transfer.
  - Required: exactly one follow-up transfer shows 8.
- Blink toggle only, i_blink 1→0:
  - Required: one digit transfer with o_dp=0.
  - Required: i_colon_en=0 gives o_dp=0 regardless of i_blink.
- Coalescing:
  - Stimulus: three i_time_change pulses plus i_config_req while WAIT.
  - Required: exactly one config transfer then one digit transfer afterwards, config first.
- Timeout:
  - Stimulus: model never acks.
  - Required: after 64 cycles state returns to IDLE, o_timeout=1, o_stb reasserts for the same transfer type.
  - Required: o_timeout stays 1 after a later successful ack.
- Refresh and reset:
  - Stimulus: idle 1000 cycles.
  - Required: config then digit transfer occur.
  - Stimulus: assert i_reset during WAIT.
  - Required: o_stb=0 and all outputs 0 in the same cycle. The post-release sequence repeats the reset scenario.
